// File: rtl/spi_reader.sv
// SPI mode-0 slave byte transceiver, oversampled in the i_clk domain, MSB first, no chip select.
// Receive updates land <=2 clk after an spi_clk rise; miso advances 2 clk after a fall.
module spi_reader (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_clk,
  input  logic       i_mosi,
  input  logic [7:0] i_to_output,
  output logic       o_miso,
  output logic [7:0] o_data,
  output logic       o_received,
  output logic       o_transmission_started
);

  logic       r_sclk_q;
  logic       r_sclk_d;
  logic       r_mosi_q;
  logic [6:0] r_shift;
  logic [2:0] r_rx_cnt;
  logic [2:0] r_tx_idx;
  logic [7:0] r_data;
  logic       r_received;

  logic       w_rise;
  logic       w_fall;
  logic [2:0] w_tx_bit;

  assign w_rise = r_sclk_q & ~r_sclk_d;
  assign w_fall = ~r_sclk_q & r_sclk_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_q <= 1'b0;
      r_sclk_d <= 1'b0;
      r_mosi_q <= 1'b0;
    end else begin
      r_sclk_q <= i_spi_clk;
      r_sclk_d <= r_sclk_q;
      r_mosi_q <= i_mosi;
    end
  end

  // Only seven bits of history are kept: the eighth comes straight from r_mosi_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= 7'd0;
      r_rx_cnt   <= 3'd0;
      r_data     <= 8'd0;
      r_received <= 1'b0;
    end else begin
      r_received <= 1'b0;
      if (w_rise) begin
        r_shift  <= {r_shift[5:0], r_mosi_q};
        r_rx_cnt <= r_rx_cnt + 3'd1;
        if (r_rx_cnt == 3'd7) begin
          r_data     <= {r_shift, r_mosi_q};
          r_received <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_idx <= 3'd0;
    end else if (w_fall) begin
      r_tx_idx <= r_tx_idx + 3'd1;
    end
  end

  // to_output is not latched, so a mid-byte change shows up on miso at once.
  assign w_tx_bit               = 3'd7 - r_tx_idx;
  assign o_miso                 = i_to_output[w_tx_bit];
  assign o_data                 = r_data;
  assign o_received             = r_received;
  assign o_transmission_started = (r_rx_cnt == 3'd1);

endmodule

// File: tb/tb_spi_reader.sv
// Randomized + directed bench for spi_reader against a bit-counting reference model.
module tb_spi_reader;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_spi_clk = 1'b0;
  logic       i_mosi = 1'b0;
  logic [7:0] i_to_output = 8'd0;
  logic       o_miso;
  logic [7:0] o_data;
  logic       o_received;
  logic       o_transmission_started;

  spi_reader dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_spi_clk              (i_spi_clk),
    .i_mosi                 (i_mosi),
    .i_to_output            (i_to_output),
    .o_miso                 (o_miso),
    .o_data                 (o_data),
    .o_received             (o_received),
    .o_transmission_started (o_transmission_started)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits received since the last reset, and the bytes they form.
  bit         bits_q[$];
  logic [7:0] exp_data = 8'd0;
  int         exp_pulses = 0;
  int         pulse_cnt = 0;

  always @(negedge i_clk) begin
    if (o_received) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_miso();
    int idx;
    logic [7:0] t;
    t   = i_to_output;
    idx = 7 - (bits_q.size() % 8);
    return t[idx];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_data"}, {24'd0, o_data}, {24'd0, exp_data});
    chk({tag, "_pulses"}, pulse_cnt, exp_pulses);
    chk({tag, "_tstart"}, {31'd0, o_transmission_started},
        {31'd0, ((bits_q.size() % 8) == 1)});
    chk({tag, "_miso"}, {31'd0, o_miso}, {31'd0, exp_miso()});
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst     = 1'b1;
    i_spi_clk = 1'b0;
    i_mosi    = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    bits_q.delete();
    exp_data = 8'd0;
    @(negedge i_clk);
  endtask

  // One SPI bit: mosi set a clk ahead of the rise, 3P high, 3P low, then check.
  task automatic send_bit(input bit b);
    int n;
    logic [7:0] byte_v;
    i_mosi = b;
    @(negedge i_clk);
    i_spi_clk = 1'b1;
    repeat (3) @(negedge i_clk);
    i_spi_clk = 1'b0;
    repeat (3) @(negedge i_clk);
    bits_q.push_back(b);
    n = bits_q.size();
    if (n % 8 == 0) begin
      byte_v = 8'd0;
      for (int i = 0; i < 8; i++) byte_v = byte_v | (8'(bits_q[n - 8 + i]) << (7 - i));
      exp_data = byte_v;
      exp_pulses++;
    end
    check_state("bit");
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    i_to_output = 8'h80;
    repeat (8) @(negedge i_clk);
    check_state("reset");

    // Directed receive: 0xCB then 0xF0 back to back.
    send_byte(8'hCB);
    chk("byte_cb", {24'd0, o_data}, 32'hCB);
    send_byte(8'hF0);
    chk("byte_f0", {24'd0, o_data}, 32'hF0);

    // Transmit 0xD2 after a reset.
    do_reset();
    i_to_output = 8'hD2;
    #1;
    chk("tx_first", {31'd0, o_miso}, 32'd1);
    send_byte(8'h00);

    // to_output changes after six bits.
    i_to_output = 8'hAB;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    i_to_output = 8'h0A;
    #1;
    chk("tx_change", {31'd0, o_miso}, 32'd1);
    send_bit(1'b0);
    chk("tx_bit0", {31'd0, o_miso}, 32'd0);
    send_bit(1'b1);
    chk("rx_after_change", {24'd0, o_data}, 32'hFD);

    // Reset mid-byte discards the partial byte.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset();
    check_state("mid_reset");
    send_byte(8'h5A);
    chk("byte_5a", {24'd0, o_data}, 32'h5A);

    // Random traffic with occasional mid-byte to_output changes and resets.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      i_to_output = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 5) == 0) i_to_output = 8'($urandom);
        send_bit(1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
